// File: rtl/two_way_round_robin_arbiter_pkg.sv
// two_way_round_robin_arbiter_pkg: shared state and select encodings for the two-way arbiter
package two_way_round_robin_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT1 = 2'd1,
        ST_GRANT2 = 2'd2
    } state_t;
    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;
endpackage

// File: rtl/two_way_round_robin_arbiter_mux.sv
// two_way_single_bit_multiplexer: one-bit 2:1 mux, select 0 routes in1, 1 routes in2
module two_way_single_bit_multiplexer (
    input  logic in1,
    input  logic in2,
    input  logic select,
    output logic out
);
    assign out = select ? in2 : in1;
endmodule

// File: rtl/two_way_round_robin_arbiter.sv
// two_way_round_robin_arbiter: round-robin owner of a shared 2:1 mux with a hold cap under contention
module two_way_round_robin_arbiter
    import two_way_round_robin_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int MAX_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req1,
    input  logic                  req2,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  gnt1,
    output logic                  gnt2,
    output logic                  select,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid
);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    state_t state, state_nxt;
    logic [CW-1:0] hold_cnt, hold_cnt_nxt;
    logic last2, last2_nxt, sel_nxt, entry;
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:   state_nxt = (req1 && req2) ? (last2 ? ST_GRANT1 : ST_GRANT2) :
                                   req1 ? ST_GRANT1 : req2 ? ST_GRANT2 : ST_IDLE;
            ST_GRANT1: state_nxt = (!req1 || (req2 && hold_cnt == HOLD_LAST)) ?
                                   (req2 ? ST_GRANT2 : ST_IDLE) : ST_GRANT1;
            ST_GRANT2: state_nxt = (!req2 || (req1 && hold_cnt == HOLD_LAST)) ?
                                   (req1 ? ST_GRANT1 : ST_IDLE) : ST_GRANT2;
            default:   state_nxt = ST_IDLE;
        endcase
        entry = (state_nxt != state) && (state_nxt != ST_IDLE);
        // counter saturates while the owner is unopposed, so a late rival forces an immediate switch
        hold_cnt_nxt = (entry || state_nxt == ST_IDLE) ? '0 :
                       (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
        last2_nxt = entry ? (state_nxt == ST_GRANT2) : last2;
        sel_nxt = entry ? ((state_nxt == ST_GRANT2) ? SEL_IN2 : SEL_IN1) : select;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            last2    <= 1'b1;
            select   <= SEL_IN1;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            last2    <= last2_nxt;
            select   <= sel_nxt;
        end
    end
    assign gnt1      = (state == ST_GRANT1);
    assign gnt2      = (state == ST_GRANT2);
    assign out_valid = gnt1 | gnt2;
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mux
        two_way_single_bit_multiplexer u_mux (
            .in1   (in1[i]),
            .in2   (in2[i]),
            .select(select),
            .out   (out[i])
        );
    end
endmodule

// File: doc/two_way_round_robin_arbiter.md
Name: two_way_round_robin_arbiter

Overview:
- Shares one 2:1 multiplexer datapath between two requesters.
- Each requester raises a request and holds it for the length of its transfer. The arbiter grants one requester at a time, drives the mux select and marks the shared output valid.
- Fairness: alternates priority between requesters and caps each grant at MAX_HOLD cycles when the other side is waiting.
- Sits between requester logic and the consumer of the shared output.

Parameters:
DATA_WIDTH, 1, width of each requester data bus and of out
MAX_HOLD, 4, maximum consecutive grant cycles while the other requester waits; legal range >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req1  input  1  requester 1 wants the shared path
req2  input  1  requester 2 wants the shared path
in1  input  DATA_WIDTH  requester 1 data
in2  input  DATA_WIDTH  requester 2 data
gnt1  output  1  requester 1 owns the path (registered)
gnt2  output  1  requester 2 owns the path (registered)
select  output  1  mux select; 0 routes in1, 1 routes in2 (registered)
out  output  DATA_WIDTH  shared output, combinational mux of in1/in2 by select
out_valid  output  1  gnt1 | gnt2

Behaviour:
- Clocking and reset: one clock; rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE; gnt1 = gnt2 = 0; select = 0; out_valid = 0.
  - hold_cnt = 0; last_grant = 2, so requester 1 wins the first contention.
- States: IDLE, GRANT1, GRANT2. gnt1 = 1 only in GRANT1 and gnt2 = 1 only in GRANT2; both are never high together.
- Latency: req is sampled on a rising edge; gnt rises on that same edge, i.e. it is visible one cycle after req is first seen high.
- IDLE:
  - req1 only -> GRANT1.
  - req2 only -> GRANT2.
  - Both -> the requester not equal to last_grant.
  - Neither -> stay in IDLE; select holds its last value.
- GRANTn, hold_cnt increments each cycle in the state:
  - Owner drops req while the other requests -> switch straight to the other grant next cycle; no idle bubble.
  - Owner drops req while the other is idle -> IDLE.
  - Owner keeps req, other requests, and hold_cnt == MAX_HOLD-1 -> forced switch to the other grant.
  - Owner keeps req, other idle -> stay; hold_cnt saturates at MAX_HOLD-1.
- On every grant entry: hold_cnt := 0; last_grant := new owner; select := 0 for GRANT1, 1 for GRANT2. select changes on the same edge as gnt.
- Counter width: $clog2(MAX_HOLD+1) bits.
- MAX_HOLD = 1 means strict alternation every cycle under continuous contention.
- Data routing: out follows the mux combinationally. In IDLE, out still reflects the held select, but out_valid = 0 and consumers ignore it.
- Reset mid-grant: gnt, select and out_valid drop immediately (asynchronously); after release, arbitration restarts with requester 1 priority.
- Requesters must hold data stable while granted. The arbiter does not check this.

Decomposition:
- Shared package:
  - State encoding constants ST_IDLE = 2'd0, ST_GRANT1 = 2'd1, ST_GRANT2 = 2'd2.
  - Select constants SEL_IN1 = 1'b0, SEL_IN2 = 1'b1.
- Sub-module: the existing two_way_single_bit_multiplexer, instantiated once per data bit in a generate loop and driven by the registered select. Arbitration FSM and counter stay in this module.

Test Plan:
1. Reset with req1=req2=1 held -> during reset gnt1=gnt2=0, select=0. First edge after release: gnt1=1, select=0, out=in1.
2. req2 only, in2=1, in1=0 -> one cycle later gnt2=1, select=1, out=1, out_valid=1. Drop req2 -> next cycle IDLE, out_valid=0, select stays 1.
3. MAX_HOLD=4, req1 and req2 held high continuously -> pattern of 4 cycles gnt1 then 4 cycles gnt2, repeating, with no cycle where both gnt or neither gnt.
4. GRANT1 active, req1 drops on the same cycle req2 is high -> next cycle gnt2=1, with no IDLE bubble.
5. Both requests arrive simultaneously from IDLE after last owner was 1 -> gnt2 wins.
6. Assert rst_n=0 mid-GRANT2, between clock edges -> gnt2, out_valid and select fall immediately. After release with both requests high, gnt1 wins.
